// File: rtl/aclk_key_entry.sv
// Keypad entry for the alarm clock: collects ASCII digits into a BCD HHMM value and commits it
// as a new time ('T') or alarm ('A'). Define ACLK_RANGE_CHECK_EN to reject HH>23 or MM>59.
module aclk_key_entry #(
  parameter int DIGITS      = 4,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            char_in,
  input  logic                  char_valid,
  output logic                  char_ready,
  output logic [3:0]            key,
  output logic                  show_new_time,
  output logic [4*DIGITS-1:0]   new_time,
  output logic                  load_new_time,
  output logic                  load_alarm,
  output logic                  entry_error
);

  localparam int BUF_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(DIGITS + 1);
  localparam int TMR_W = $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ENTRY  = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [BUF_W-1:0]   buf_q, buf_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [3:0]         key_q, key_d;
  logic [BUF_W-1:0]   new_time_q, new_time_d;
  logic               ready_q, ready_d;
  logic               show_q, show_d;
  logic               load_time_q, load_time_d;
  logic               load_alarm_q, load_alarm_d;
  logic               error_q, error_d;

  logic               xfer;
  logic               is_digit;
  logic               is_time;
  logic               is_alarm;
  logic               is_clear;
  logic [3:0]         digit;
  logic               full;
  logic               commit_ok;

`ifdef ACLK_RANGE_CHECK_EN
  // Only a four-digit HHMM buffer has a meaningful clock range; other widths always pass.
  function automatic logic range_ok(input logic [BUF_W-1:0] v);
    logic [15:0] w;
    logic [7:0]  hh;
    logic [7:0]  mm;
    w  = 16'(v);
    hh = {4'd0, w[15:12]} * 8'd10 + {4'd0, w[11:8]};
    mm = {4'd0, w[7:4]} * 8'd10 + {4'd0, w[3:0]};
    return (DIGITS != 4) || ((hh <= 8'd23) && (mm <= 8'd59));
  endfunction

  assign commit_ok = range_ok(buf_q);
`else
  assign commit_ok = 1'b1;
`endif

  assign xfer     = char_valid & ready_q;
  assign is_digit = (char_in >= 8'h30) && (char_in <= 8'h39);
  assign is_time  = (char_in == 8'h54);
  assign is_alarm = (char_in == 8'h41);
  assign is_clear = (char_in == 8'h2A);
  assign digit    = char_in[3:0];
  assign full     = (count_q == CNT_W'(DIGITS));

  always_comb begin
    state_d      = state_q;
    buf_d        = buf_q;
    count_d      = count_q;
    timer_d      = timer_q;
    key_d        = key_q;
    new_time_d   = new_time_q;
    load_time_d  = 1'b0;
    load_alarm_d = 1'b0;
    error_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (xfer) begin
          if (is_digit) begin
            buf_d   = BUF_W'(digit);
            count_d = CNT_W'(1);
            key_d   = digit;
            state_d = S_ENTRY;
          end else if (!is_clear) begin
            error_d = 1'b1;
          end
        end
      end

      S_ENTRY: begin
        if (xfer) begin
          timer_d = '0;
          if (is_digit) begin
            if (!full) begin
              buf_d   = (buf_q << 4) | BUF_W'(digit);
              count_d = count_q + CNT_W'(1);
              key_d   = digit;
            end else begin
              error_d = 1'b1;
            end
          end else if (is_time || is_alarm) begin
            if (full && commit_ok) begin
              new_time_d   = buf_q;
              load_time_d  = is_time;
              load_alarm_d = is_alarm;
              buf_d        = '0;
              count_d      = '0;
              state_d      = S_COMMIT;
            end else begin
              error_d = 1'b1;
            end
          end else if (is_clear) begin
            buf_d   = '0;
            count_d = '0;
            state_d = S_IDLE;
          end else begin
            error_d = 1'b1;
          end
        end else if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
          // Abandoned entry: drop the partial value and flag it.
          buf_d   = '0;
          count_d = '0;
          timer_d = '0;
          error_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      S_COMMIT: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        buf_d   = '0;
        count_d = '0;
        timer_d = '0;
      end
    endcase

    ready_d = (state_d != S_COMMIT);
    show_d  = (state_d == S_ENTRY);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      buf_q        <= '0;
      count_q      <= '0;
      timer_q      <= '0;
      key_q        <= '0;
      new_time_q   <= '0;
      ready_q      <= 1'b0;
      show_q       <= 1'b0;
      load_time_q  <= 1'b0;
      load_alarm_q <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      count_q      <= count_d;
      timer_q      <= timer_d;
      key_q        <= key_d;
      new_time_q   <= new_time_d;
      ready_q      <= ready_d;
      show_q       <= show_d;
      load_time_q  <= load_time_d;
      load_alarm_q <= load_alarm_d;
      error_q      <= error_d;
    end
  end

  assign char_ready    = ready_q;
  assign key           = key_q;
  assign show_new_time = show_q;
  assign new_time      = new_time_q;
  assign load_new_time = load_time_q;
  assign load_alarm    = load_alarm_q;
  assign entry_error   = error_q;

endmodule

// File: tb/tb_aclk_key_entry.sv
// Directed bench for aclk_key_entry: reset, time/alarm commits, errors, timeout, range check.
module tb_aclk_key_entry;

  localparam int DIGITS = 4;
  localparam int TO     = 16;

  logic        clk;
  logic        reset;
  logic [7:0]  char_in;
  logic        char_valid;
  logic        char_ready;
  logic [3:0]  key;
  logic        show_new_time;
  logic [15:0] new_time;
  logic        load_new_time;
  logic        load_alarm;
  logic        entry_error;

  int vectors     = 0;
  int miscompares = 0;

  aclk_key_entry #(.DIGITS(DIGITS), .TIMEOUT_CYC(TO)) dut (
    .clk           (clk),
    .reset         (reset),
    .char_in       (char_in),
    .char_valid    (char_valid),
    .char_ready    (char_ready),
    .key           (key),
    .show_new_time (show_new_time),
    .new_time      (new_time),
    .load_new_time (load_new_time),
    .load_alarm    (load_alarm),
    .entry_error   (entry_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one character and return 1 time unit after the edge that accepts it.
  task automatic send(input logic [7:0] ch);
    @(negedge clk);
    for (int i = 0; i < 8 && !char_ready; i++) @(negedge clk);
    chk("char_ready_before_send", {31'd0, char_ready}, 32'd1);
    char_in    = ch;
    char_valid = 1'b1;
    @(posedge clk);
    #1;
    char_valid = 1'b0;
    char_in    = 8'h00;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset      = 1'b0;
    char_valid = 1'b0;
    char_in    = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Reset in the middle of an entry
    send("1");
    send("2");
    chk("pre_reset_show", {31'd0, show_new_time}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    step();
    step();
    chk("rst_ready", {31'd0, char_ready}, 32'd0);
    chk("rst_key", {28'd0, key}, 32'd0);
    chk("rst_show", {31'd0, show_new_time}, 32'd0);
    chk("rst_new_time", {16'd0, new_time}, 32'd0);
    chk("rst_pulses", {29'd0, load_new_time, load_alarm, entry_error}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    step();
    chk("ready_after_release", {31'd0, char_ready}, 32'd1);
    chk("show_after_release", {31'd0, show_new_time}, 32'd0);

    // Time commit 12:30
    send("1"); chk("t_key1", {28'd0, key}, 32'd1);
    chk("t_show", {31'd0, show_new_time}, 32'd1);
    send("2"); chk("t_key2", {28'd0, key}, 32'd2);
    send("3"); chk("t_key3", {28'd0, key}, 32'd3);
    send("0"); chk("t_key0", {28'd0, key}, 32'd0);
    chk("t_new_time_held", {16'd0, new_time}, 32'd0);
    send("T");
    chk("t_new_time", {16'd0, new_time}, 32'h1230);
    chk("t_load_time", {31'd0, load_new_time}, 32'd1);
    chk("t_load_alarm", {31'd0, load_alarm}, 32'd0);
    chk("t_error", {31'd0, entry_error}, 32'd0);
    chk("t_show_fall", {31'd0, show_new_time}, 32'd0);
    chk("t_commit_ready", {31'd0, char_ready}, 32'd0);
    step();
    chk("t_pulse_end", {31'd0, load_new_time}, 32'd0);
    chk("t_ready_back", {31'd0, char_ready}, 32'd1);

    // Alarm commit 07:45
    send("0"); send("7"); send("4"); send("5");
    chk("a_key", {28'd0, key}, 32'd5);
    send("A");
    chk("a_new_time", {16'd0, new_time}, 32'h0745);
    chk("a_load_alarm", {31'd0, load_alarm}, 32'd1);
    chk("a_load_time", {31'd0, load_new_time}, 32'd0);
    step();
    chk("a_pulse_end", {31'd0, load_alarm}, 32'd0);

    // Fifth digit is rejected
    send("1"); send("2"); send("3"); send("4");
    send("5");
    chk("d5_error", {31'd0, entry_error}, 32'd1);
    chk("d5_key", {28'd0, key}, 32'd4);
    chk("d5_new_time", {16'd0, new_time}, 32'h0745);
    chk("d5_show", {31'd0, show_new_time}, 32'd1);
    send("*");
    chk("d5_clear_show", {31'd0, show_new_time}, 32'd0);
    chk("d5_clear_err", {31'd0, entry_error}, 32'd0);

    // Short commit, clear, idle-state errors
    send("1"); send("2"); send("T");
    chk("short_error", {31'd0, entry_error}, 32'd1);
    chk("short_load", {31'd0, load_new_time}, 32'd0);
    chk("short_show", {31'd0, show_new_time}, 32'd1);
    send("*");
    chk("clr_show", {31'd0, show_new_time}, 32'd0);
    send("*");
    chk("idle_clr_noerr", {31'd0, entry_error}, 32'd0);
    send("X");
    chk("idle_x_error", {31'd0, entry_error}, 32'd1);
    chk("idle_x_key", {28'd0, key}, 32'd2);
    send("A");
    chk("idle_a_error", {31'd0, entry_error}, 32'd1);
    chk("idle_a_noload", {31'd0, load_alarm}, 32'd0);

    // Timeout after TO idle cycles in ENTRY
    send("9");
    chk("to_key", {28'd0, key}, 32'd9);
    repeat (TO - 1) @(posedge clk);
    #1;
    chk("to_not_yet", {31'd0, entry_error}, 32'd0);
    chk("to_still_show", {31'd0, show_new_time}, 32'd1);
    step();
    chk("to_error", {31'd0, entry_error}, 32'd1);
    chk("to_show_fall", {31'd0, show_new_time}, 32'd0);
    step();
    chk("to_pulse_end", {31'd0, entry_error}, 32'd0);

    // A digit on the final cycle beats the timeout
    send("9");
    repeat (TO - 1) @(posedge clk);
    send("5");
    chk("race_key", {28'd0, key}, 32'd5);
    chk("race_no_error", {31'd0, entry_error}, 32'd0);
    chk("race_show", {31'd0, show_new_time}, 32'd1);
    step();
    chk("race_no_error2", {31'd0, entry_error}, 32'd0);
    send("*");

    // 25:00 entry
    send("2"); send("5"); send("0"); send("0"); send("T");
`ifdef ACLK_RANGE_CHECK_EN
    chk("rng_error", {31'd0, entry_error}, 32'd1);
    chk("rng_noload", {31'd0, load_new_time}, 32'd0);
    chk("rng_new_time", {16'd0, new_time}, 32'h0745);
    chk("rng_show", {31'd0, show_new_time}, 32'd1);
`else
    chk("rng_load", {31'd0, load_new_time}, 32'd1);
    chk("rng_noerror", {31'd0, entry_error}, 32'd0);
    chk("rng_new_time", {16'd0, new_time}, 32'h2500);
`endif
    step();
    send("*");
    chk("final_show", {31'd0, show_new_time}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
